// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle for one pipeline stage boundary.
// slave is the stage register, master is whatever drives it.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 12,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int N_DATA = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [TAG_W-1:0]         in_tag;
    logic [N_DATA*DATA_W-1:0] in_data;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [CTRL_W-1:0]        out_ctrl;
    logic [TAG_W-1:0]         out_tag;
    logic [N_DATA*DATA_W-1:0] out_data;
    logic [1:0]               occupancy;

    modport slave (
        input  in_valid, in_ctrl, in_tag, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_tag, out_data, occupancy
    );

    modport master (
        output in_valid, in_ctrl, in_tag, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_tag, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, flush-to-bubble and
// valid/ready flow control. State updates on the falling edge of clk.
module pipe_stage_skid #(
    parameter int CTRL_W = 12,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int N_DATA = 3
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_skid_if.slave  bus
);
    localparam int DW = N_DATA * DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [TAG_W-1:0]  tag;
        logic [DW-1:0]     data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, in_ent;
    logic   main_v, skid_v, xfer_in, xfer_out;
    logic   ld_main_in, ld_main_skid, ld_skid_in;

    // Valid bits are decoded from registered state only, so in_ready never
    // depends combinationally on out_ready or flush.
    assign main_v   = (state_q != EMPTY);
    assign skid_v   = (state_q == TWO);
    assign xfer_in  = bus.in_valid && !skid_v;
    assign xfer_out = main_v && bus.out_ready;
    assign in_ent   = '{ctrl: bus.in_ctrl, tag: bus.in_tag, data: bus.in_data};

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (xfer_in) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
                ONE: case ({xfer_in, xfer_out})
                    2'b10: begin state_d = TWO;   ld_skid_in = 1'b1; end
                    2'b01: begin state_d = EMPTY;                    end
                    2'b11: begin state_d = ONE;   ld_main_in = 1'b1; end
                    default: state_d = ONE;
                endcase
                TWO: if (xfer_out) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Flush zeroes only ctrl; tag/data may go stale since they are
    // don't-care while the entry is invalid.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            main_q.ctrl <= '0;
            skid_q.ctrl <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_ent;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid_in)        skid_q <= in_ent;
        end
    end

    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = main_v;
    assign bus.out_ctrl  = main_v ? main_q.ctrl : '0;
    assign bus.out_tag   = main_q.tag;
    assign bus.out_data  = main_q.data;
    assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: a capacity-2 FIFO model predicts every output of the
// default instance; a second, narrower instance gets directed checks.
module tb_pipe_stage_skid;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    pipe_stage_skid_if #(.CTRL_W(12), .TAG_W(4), .DATA_W(32), .N_DATA(3)) bus ();
    pipe_stage_skid_if #(.CTRL_W(8), .TAG_W(5), .DATA_W(16), .N_DATA(2)) bus2 ();

    pipe_stage_skid #(.CTRL_W(12), .TAG_W(4), .DATA_W(32), .N_DATA(3)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    pipe_stage_skid #(.CTRL_W(8), .TAG_W(5), .DATA_W(16), .N_DATA(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [11:0] c;
        logic [3:0]  t;
        logic [95:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // One clock of stimulus on the default instance. Inputs change at
    // posedge+1; the model is updated at posedge+3, after the monitor pop.
    task automatic cycle(input bit iv, input logic [11:0] c, input logic [3:0] t,
                         input logic [95:0] d, input bit ordy, input bit fl);
        bit acc;
        ent_t e;
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.in_ctrl   = c;
        bus.in_tag    = t;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        acc = iv && (exp_q.size() < 2);
        #2;
        if (fl) exp_q.delete();
        else if (acc) begin
            e.c = c; e.t = t; e.d = d;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares the DUT against the head of the model each cycle
    // and retires the head when the downstream takes it.
    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("empty out_valid", 128'(bus.out_valid), 128'(0));
                chk("empty out_ctrl", 128'(bus.out_ctrl), 128'(0));
                chk("empty occupancy", 128'(bus.occupancy), 128'(0));
                chk("empty in_ready", 128'(bus.in_ready), 128'(1));
            end else begin
                chk("out_valid", 128'(bus.out_valid), 128'(1));
                chk("occupancy", 128'(bus.occupancy), 128'(exp_q.size()));
                chk("in_ready", 128'(bus.in_ready), 128'(exp_q.size() < 2));
                chk("out_ctrl", 128'(bus.out_ctrl), 128'(exp_q[0].c));
                chk("out_tag", 128'(bus.out_tag), 128'(exp_q[0].t));
                chk("out_data", 128'(bus.out_data), 128'(exp_q[0].d));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step2(input bit iv, input logic [7:0] c, input logic [4:0] t,
                         input logic [31:0] d, input bit ordy);
        @(posedge clk);
        #1;
        bus2.in_valid  = iv;
        bus2.in_ctrl   = c;
        bus2.in_tag    = t;
        bus2.in_data   = d;
        bus2.out_ready = ordy;
        @(negedge clk);
        #2;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_ctrl = '0; bus.in_tag = '0; bus.in_data = '0;
        bus.flush = 0; bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_ctrl = '0; bus2.in_tag = '0; bus2.in_data = '0;
        bus2.flush = 0; bus2.out_ready = 0;

        #1 rst = 1'b1;
        #1;
        chk("reset out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset occupancy", 128'(bus.occupancy), 128'(0));
        @(posedge clk);
        #6 rst = 1'b0;

        // streaming 1..4 at full throughput
        for (int k = 1; k <= 4; k++) cycle(1, 12'h0A1, 4'h1, 96'(k), 1, 0);
        cycle(0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);

        // backpressure: A, B held, C refused until drained
        cycle(1, 12'h101, 4'h3, 96'hA, 0, 0);
        cycle(1, 12'h102, 4'h5, 96'hB, 0, 0);
        cycle(1, 12'h103, 4'h9, 96'hC, 0, 0);
        cycle(1, 12'h103, 4'h9, 96'hC, 1, 0);
        cycle(1, 12'h103, 4'h9, 96'hC, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);

        // flush while full with an entry on offer, then a normal entry
        cycle(1, 12'hFFF, 4'h1, 96'h1, 0, 0);
        cycle(1, 12'hFFF, 4'h2, 96'h2, 0, 0);
        cycle(1, 12'hFFF, 4'h3, 96'h3, 0, 1);
        cycle(1, 12'h0D0, 4'h4, 96'hD, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);

        // simultaneous push/pop in ONE
        cycle(1, 12'h0E0, 4'h6, 96'hE0, 0, 0);
        cycle(1, 12'h0E1, 4'h7, 96'hE1, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);

        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, 12'($urandom), 4'($urandom),
                  {$urandom, $urandom, $urandom},
                  ($urandom % 3) != 0, ($urandom % 16) == 0);

        // asynchronous reset while full
        cycle(0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);
        cycle(0, '0, '0, '0, 1, 0);
        cycle(1, 12'h011, 4'h1, 96'h11, 0, 0);
        cycle(1, 12'h022, 4'h2, 96'h22, 0, 0);
        cycle(0, '0, '0, '0, 0, 0);
        chk("pre-reset occupancy", 128'(bus.occupancy), 128'(2));
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("async rst out_ctrl", 128'(bus.out_ctrl), 128'(0));
        chk("async rst out_tag", 128'(bus.out_tag), 128'(0));
        chk("async rst out_data", 128'(bus.out_data), 128'(0));
        chk("async rst occupancy", 128'(bus.occupancy), 128'(0));
        chk("async rst in_ready", 128'(bus.in_ready), 128'(1));
        exp_q.delete();
        @(posedge clk);
        #6 rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, 0, 0);

        // narrow instance: bit-exact payload
        step2(1, 8'hA5, 5'h13, 32'hBEEF_1234, 0);
        chk("p2 out_data", 128'(bus2.out_data), 128'h BEEF_1234);
        chk("p2 out_tag", 128'(bus2.out_tag), 128'h13);
        chk("p2 out_ctrl", 128'(bus2.out_ctrl), 128'hA5);
        step2(0, '0, '0, '0, 1);
        chk("p2 drained", 128'(bus2.out_valid), 128'(0));
        chk("p2 bubble ctrl", 128'(bus2.out_ctrl), 128'(0));
        // narrow instance: streaming
        for (int k = 1; k <= 4; k++) begin
            step2(1, 8'h01, 5'h01, 32'(k), 1);
            chk("p2 stream data", 128'(bus2.out_data), 128'(k));
            chk("p2 stream occ", 128'(bus2.occupancy), 128'(1));
        end
        step2(0, '0, '0, '0, 1);
        // narrow instance: backpressure
        step2(1, 8'h0A, 5'd3, 32'hA, 0);
        step2(1, 8'h0B, 5'd5, 32'hB, 0);
        chk("p2 bp occ", 128'(bus2.occupancy), 128'(2));
        chk("p2 bp in_ready", 128'(bus2.in_ready), 128'(0));
        step2(1, 8'h0C, 5'd7, 32'hC, 0);
        chk("p2 bp hold tag", 128'(bus2.out_tag), 128'(3));
        chk("p2 bp hold occ", 128'(bus2.occupancy), 128'(2));
        step2(1, 8'h0C, 5'd7, 32'hC, 1);
        chk("p2 bp tag B", 128'(bus2.out_tag), 128'(5));
        chk("p2 bp occ B", 128'(bus2.occupancy), 128'(1));
        step2(1, 8'h0C, 5'd7, 32'hC, 1);
        chk("p2 bp tag C", 128'(bus2.out_tag), 128'(7));
        chk("p2 bp data C", 128'(bus2.out_data), 128'hC);
        step2(0, '0, '0, '0, 1);
        chk("p2 bp empty", 128'(bus2.out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
